sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Parametrised N-to-1 arbiter for the core's SRAM-like bus (req/addr_ok/data_ok). It replaces the fixed split of one instruction port plus one data port with NUM_CH master channels sharing one slave port. It tracks up to OUTSTANDING accepted requests so each data_ok is routed back to the channel that issued it. Per-channel cancel drops in-flight responses after a pipeline flush (exception, ertn, refetch).

## Interface
- NUM_CH, default 2: number of master channels (≥2).
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width; strobe width is DATA_W/8.
- OUTSTANDING, default 4: response queue depth (power of 2, ≥2).
- RR_MODE, default 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- m_req  in  NUM_CH  per-channel request.
- m_wr  in  NUM_CH  1 = write.
- m_size  in  2*NUM_CH  byte/half/word size.
- m_wstrb  in  NUM_CH*DATA_W/8  write strobes.
- m_addr  in  NUM_CH*ADDR_W  addresses.
- m_wdata  in  NUM_CH*DATA_W  write data.
- m_cancel  in  NUM_CH  discard all in-flight responses of the channel.
- m_addr_ok  out  NUM_CH  request accepted.
- m_data_ok  out  NUM_CH  response returned.
- m_rdata  out  NUM_CH*DATA_W  read data; s_rdata broadcast to every slice.
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/DATA_W/8/ADDR_W/DATA_W  slave request.
- s_addr_ok, s_data_ok  in  1  slave handshakes.
- s_rdata  in  DATA_W  slave read data.

## Operation
- Eligible channel: m_req[i]=1 and queue count < OUTSTANDING. A pop in the same cycle does not free a slot.
- State IDLE:
  - When any channel is eligible, pick a winner combinationally; s_req=1 and s_* are muxed from the winner in the same cycle.
  - If s_addr_ok=1, the handshake completes and the state stays IDLE.
  - Otherwise latch lock_ch=winner and go to LOCKED.
- State LOCKED:
  - s_req=1; s_* come from lock_ch regardless of other requests or priority.
  - On s_addr_ok, return to IDLE.
  - The master must hold its request stable; that is a protocol requirement, not checked.
- m_addr_ok[i] = s_req & s_addr_ok & (selected == i).
- Round-robin: pointer last = channel of the most recent handshake; search starts at last+1 and wraps modulo NUM_CH. Pointer updates only on handshake.
- Queue (in-order FIFO of {ch, discard}):
  - Push on s_req & s_addr_ok.
  - Pop on s_data_ok. If head.discard=0, m_data_ok[head.ch]=1; otherwise all m_data_ok stay 0.
  - Simultaneous push and pop leave count unchanged.
  - s_data_ok while the queue is empty is ignored; count stays 0.
- Cancel:
  - m_cancel[i] sets discard on every valid entry with ch==i.
  - It also applies to an entry pushed in the same cycle, and to the locked request via a lock_discard flag that is carried into its push.
  - Cancel never withdraws s_req.
  - An entry popped in the same cycle as cancel is already delivered and is not suppressed.
- Reset (resetn=0 at a clk edge):
  - Queue empty, count=0, state IDLE, lock_discard=0, pointer=NUM_CH-1 so channel 0 wins first.
  - While resetn=0, s_req=0, m_addr_ok=0, m_data_ok=0.

## Timing
- Request path is combinational (zero added cycles): m_req → s_req, s_addr_ok → m_addr_ok.
- Response path is combinational: s_data_ok/s_rdata → m_data_ok/m_rdata, same cycle.
- Queue, lock and pointer update on the rising clk edge.
- Full: with count==OUTSTANDING, s_req=0. A pop at edge t allows a new grant in cycle t+1.
- Reset mid-transaction drops all tracking. Slave responses arriving after reset are treated as empty-queue data_ok and ignored.
- Throughput: one handshake per cycle while not full.

## Test plan
- Single read: ch0 requests addr 0x1C000000, slave gives addr_ok in the same cycle and data_ok 2 cycles later with 0x12345678 → m_addr_ok[0]=1 in cycle 0; m_data_ok[0]=1 with m_rdata slice 0 = 0x12345678 in cycle 2; channel 1 sees no data_ok.
- Round-robin: RR_MODE=1, ch0 and ch1 request continuously, slave addr_ok always 1 → grants alternate 0,1,0,1. With RR_MODE=0 → ch0 wins every cycle.
- Full: OUTSTANDING=4, four accepted requests with no data_ok → 5th cycle s_req=0. One data_ok at edge t → s_req=1 and the handshake occurs in cycle t+1.
- Cancel: queue holds ch1,ch0,ch1; m_cancel[1] pulses one cycle; three data_ok returns → only the middle one raises m_data_ok[0]; m_data_ok[1] never asserts.
- Lock: RR_MODE=0; ch1 granted while the slave withholds addr_ok 3 cycles; ch0 raises req in cycle 1 → s_addr stays ch1's until addr_ok, and ch0 is granted the following cycle.
- Reset mid-operation: 2 entries outstanding, resetn=0 for 1 cycle, then s_data_ok arrives → no m_data_ok; next request is accepted normally, with ch0 first.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// N-to-1 arbiter for the SRAM-like bus (req/addr_ok/data_ok). NUM_CH masters
// share one slave port. An in-order queue of {channel, discard} records every
// accepted request so that each s_data_ok is routed back to its issuer.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   m_req/m_wr/m_size/m_wstrb/
//   m_addr/m_wdata/m_cancel      per-channel request bundle (packed, ch0 in LSBs)
//   m_addr_ok/m_data_ok/m_rdata  per-channel handshakes, s_rdata broadcast
//   s_req/s_wr/s_size/s_wstrb/
//   s_addr/s_wdata               slave request muxed from the selected channel
//   s_addr_ok/s_data_ok/s_rdata  slave handshakes and read data
module sram_like_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 4,
    parameter int RR_MODE     = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CH-1:0]          m_req,
    input  logic [NUM_CH-1:0]          m_wr,
    input  logic [2*NUM_CH-1:0]        m_size,
    input  logic [NUM_CH*DATA_W/8-1:0] m_wstrb,
    input  logic [NUM_CH*ADDR_W-1:0]   m_addr,
    input  logic [NUM_CH*DATA_W-1:0]   m_wdata,
    input  logic [NUM_CH-1:0]          m_cancel,
    output logic [NUM_CH-1:0]          m_addr_ok,
    output logic [NUM_CH-1:0]          m_data_ok,
    output logic [NUM_CH*DATA_W-1:0]   m_rdata,
    output logic                       s_req,
    output logic                       s_wr,
    output logic [1:0]                 s_size,
    output logic [DATA_W/8-1:0]        s_wstrb,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic                       s_addr_ok,
    input  logic                       s_data_ok,
    input  logic [DATA_W-1:0]          s_rdata
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int PTR_W  = $clog2(OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    // state     | meaning
    // ST_IDLE   | winner chosen combinationally each cycle
    // ST_LOCKED | slave stalled addr_ok; request held on lock_ch
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        state;
    logic [CH_W-1:0]   lock_ch;
    logic              lock_discard;
    logic [CH_W-1:0]   last;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CH_W-1:0]   q_ch   [OUTSTANDING];
    logic              q_vld  [OUTSTANDING];
    logic              q_disc [OUTSTANDING];

    logic [NUM_CH-1:0] eligible;
    logic              any_elig;
    logic              locked;
    logic [CH_W-1:0]   winner;
    logic [CH_W-1:0]   sel;
    logic              push;
    logic              pop;
    logic              push_disc;

    // A pop in the same cycle does not free a slot: compare the registered count.
    assign eligible = m_req & {NUM_CH{count < CNT_W'(OUTSTANDING)}};
    assign any_elig = |eligible;
    assign locked   = (state == ST_LOCKED);

    always_comb begin
        logic            found;
        logic [CH_W-1:0] cand;
        int              idx;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        idx    = 0;
        if (RR_MODE != 0) begin
            // Search starts one past the last granted channel and wraps.
            for (int off = 1; off <= NUM_CH; off++) begin
                idx  = (int'(last) + off) % NUM_CH;
                cand = CH_W'(idx);
                if (!found && eligible[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                cand = CH_W'(i);
                if (eligible[cand]) winner = cand;
            end
        end
    end

    assign sel   = locked ? lock_ch : winner;
    assign s_req = resetn & (locked | any_elig);
    assign push  = s_req & s_addr_ok;
    assign pop   = resetn & s_data_ok & (count != '0);

    assign s_wr    = m_wr[sel];
    assign s_size  = m_size[int'(sel)*2 +: 2];
    assign s_wstrb = m_wstrb[int'(sel)*STRB_W +: STRB_W];
    assign s_addr  = m_addr[int'(sel)*ADDR_W +: ADDR_W];
    assign s_wdata = m_wdata[int'(sel)*DATA_W +: DATA_W];
    assign m_rdata = {NUM_CH{s_rdata}};

    // A cancel raised while the request is still stalled (or in its push cycle)
    // must follow the request into the queue.
    assign push_disc = m_cancel[sel] | (locked & lock_discard);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign m_addr_ok[g] = push & (sel == CH_W'(g));
        assign m_data_ok[g] = pop & ~q_disc[rd_ptr] & (q_ch[rd_ptr] == CH_W'(g));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            lock_ch      <= '0;
            lock_discard <= 1'b0;
            last         <= CH_W'(NUM_CH - 1);
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            for (int k = 0; k < OUTSTANDING; k++) begin
                q_ch[k]   <= '0;
                q_vld[k]  <= 1'b0;
                q_disc[k] <= 1'b0;
            end
        end else begin
            // Marking the head being popped is harmless: it is already delivered.
            for (int k = 0; k < OUTSTANDING; k++) begin
                if (q_vld[k] && m_cancel[q_ch[k]]) q_disc[k] <= 1'b1;
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            // Push never targets a live slot: it requires count < OUTSTANDING.
            if (push) begin
                q_vld[wr_ptr]  <= 1'b1;
                q_ch[wr_ptr]   <= sel;
                q_disc[wr_ptr] <= push_disc;
                wr_ptr         <= wr_ptr + 1'b1;
                last           <= sel;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                ST_IDLE: begin
                    if (s_req && !s_addr_ok) begin
                        state        <= ST_LOCKED;
                        lock_ch      <= winner;
                        lock_discard <= m_cancel[winner];
                    end
                end
                default: begin
                    if (s_addr_ok) begin
                        state        <= ST_IDLE;
                        lock_discard <= 1'b0;
                    end else if (m_cancel[lock_ch]) begin
                        lock_discard <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a round-robin instance (d=0) and a fixed-priority
// instance (d=1) share all inputs. A transaction-level model (request queue of
// {channel, discard}, lock flag, last-grant pointer) predicts every output.
module tb_sram_like_arbiter;

    localparam int NC  = 3;
    localparam int OUT = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NC-1:0]   m_req, m_wr, m_cancel;
    logic [2*NC-1:0] m_size;
    logic [NC*4-1:0] m_wstrb;
    logic [NC*32-1:0] m_addr, m_wdata;
    logic            s_addr_ok, s_data_ok;
    logic [31:0]     s_rdata;

    logic [NC-1:0]    m_addr_ok_o [2];
    logic [NC-1:0]    m_data_ok_o [2];
    logic [NC*32-1:0] m_rdata_o   [2];
    logic             s_req_o     [2];
    logic             s_wr_o      [2];
    logic [1:0]       s_size_o    [2];
    logic [3:0]       s_wstrb_o   [2];
    logic [31:0]      s_addr_o    [2];
    logic [31:0]      s_wdata_o   [2];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int mq_ch   [2][8];
    bit mq_disc [2][8];
    int mcnt    [2];
    bit mlock   [2];
    int mlock_ch[2];
    bit mldisc  [2];
    int mlast   [2];

    always #5 clk = ~clk;

    sram_like_arbiter #(.NUM_CH(NC), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(OUT), .RR_MODE(1)) u_rr (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_cancel(m_cancel),
        .m_addr_ok(m_addr_ok_o[0]), .m_data_ok(m_data_ok_o[0]), .m_rdata(m_rdata_o[0]),
        .s_req(s_req_o[0]), .s_wr(s_wr_o[0]), .s_size(s_size_o[0]), .s_wstrb(s_wstrb_o[0]),
        .s_addr(s_addr_o[0]), .s_wdata(s_wdata_o[0]),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata));

    sram_like_arbiter #(.NUM_CH(NC), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(OUT), .RR_MODE(0)) u_fp (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_cancel(m_cancel),
        .m_addr_ok(m_addr_ok_o[1]), .m_data_ok(m_data_ok_o[1]), .m_rdata(m_rdata_o[1]),
        .s_req(s_req_o[1]), .s_wr(s_wr_o[1]), .s_size(s_size_o[1]), .s_wstrb(s_wstrb_o[1]),
        .s_addr(s_addr_o[1]), .s_wdata(s_wdata_o[1]),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit bit_of(input logic [NC-1:0] v, input int i);
        return ((v >> i) & NC'(1)) != '0;
    endfunction

    // Predict this cycle's outputs, compare, then advance the model to the next edge.
    task automatic check_cycle();
        for (int d = 0; d < 2; d++) begin
            bit            e_sreq, found, push, pop, cur_lock;
            int            e_sel, c;
            logic [NC-1:0] e_aok, e_dok;
            e_sreq = 0; found = 0; push = 0; pop = 0; e_sel = 0;
            e_aok = '0; e_dok = '0; cur_lock = mlock[d];
            if (resetn) begin
                if (mlock[d]) begin
                    e_sreq = 1; e_sel = mlock_ch[d];
                end else if (mcnt[d] < OUT) begin
                    if (d == 0) begin
                        for (int off = 1; off <= NC; off++) begin
                            c = (mlast[d] + off) % NC;
                            if (!found && bit_of(m_req, c)) begin found = 1; e_sel = c; end
                        end
                    end else begin
                        for (int i = 0; i < NC; i++)
                            if (!found && bit_of(m_req, i)) begin found = 1; e_sel = i; end
                    end
                    e_sreq = found;
                end
                push = e_sreq && s_addr_ok;
                if (push) e_aok = NC'(1) << e_sel;
                pop = s_data_ok && (mcnt[d] > 0);
                if (pop && !mq_disc[d][0]) e_dok = NC'(1) << mq_ch[d][0];
            end

            chk($sformatf("s_req[%0d]", d), 64'(s_req_o[d]), 64'(e_sreq));
            chk($sformatf("m_addr_ok[%0d]", d), 64'(m_addr_ok_o[d]), 64'(e_aok));
            chk($sformatf("m_data_ok[%0d]", d), 64'(m_data_ok_o[d]), 64'(e_dok));
            if (e_sreq) begin
                chk($sformatf("s_addr[%0d]", d), 64'(s_addr_o[d]), 64'(m_addr[e_sel*32 +: 32]));
                chk($sformatf("s_wdata[%0d]", d), 64'(s_wdata_o[d]), 64'(m_wdata[e_sel*32 +: 32]));
                chk($sformatf("s_ctl[%0d]", d), 64'({s_wr_o[d], s_size_o[d], s_wstrb_o[d]}),
                    64'({bit_of(m_wr, e_sel), m_size[e_sel*2 +: 2], m_wstrb[e_sel*4 +: 4]}));
            end
            if (e_dok != '0)
                chk($sformatf("m_rdata[%0d]", d), 64'(m_rdata_o[d][e_sel*0 + 32*(NC-1) +: 32]), 64'(s_rdata));

            if (!resetn) begin
                mcnt[d] = 0; mlock[d] = 0; mldisc[d] = 0; mlast[d] = NC - 1; mlock_ch[d] = 0;
            end else begin
                if (pop) begin
                    for (int k = 0; k < mcnt[d] - 1; k++) begin
                        mq_ch[d][k]   = mq_ch[d][k+1];
                        mq_disc[d][k] = mq_disc[d][k+1];
                    end
                    mcnt[d]--;
                end
                for (int k = 0; k < mcnt[d]; k++)
                    if (bit_of(m_cancel, mq_ch[d][k])) mq_disc[d][k] = 1;
                if (push) begin
                    mq_ch[d][mcnt[d]]   = e_sel;
                    mq_disc[d][mcnt[d]] = bit_of(m_cancel, e_sel) || (cur_lock && mldisc[d]);
                    mcnt[d]++;
                    mlast[d] = e_sel;
                end
                if (cur_lock) begin
                    if (s_addr_ok) begin mlock[d] = 0; mldisc[d] = 0; end
                    else if (bit_of(m_cancel, mlock_ch[d])) mldisc[d] = 1;
                end else if (e_sreq && !s_addr_ok) begin
                    mlock[d] = 1; mlock_ch[d] = e_sel; mldisc[d] = bit_of(m_cancel, e_sel);
                end
            end
        end
    endtask

    task automatic step();
        #1;
        check_cycle();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc();
        step();
        tick();
    endtask

    task automatic idle();
        resetn = 1; m_req = '0; m_cancel = '0; s_addr_ok = 0; s_data_ok = 0;
    endtask

    task automatic do_reset();
        idle(); resetn = 0;
        step();
        chk("reset_s_req", 64'(s_req_o[0]), 64'(0));
        tick();
        resetn = 1;
    endtask

    initial begin
        idle();
        m_wr = '0; m_size = '0; m_wstrb = '0; m_wdata = '0; s_rdata = '0;
        m_addr = {32'h3000_0000, 32'h2000_0000, 32'h1C00_0000};
        @(negedge clk);
        do_reset();

        // Single read: ch0, addr_ok same cycle, data_ok two cycles later
        m_req = 3'b001; s_addr_ok = 1;
        step();
        chk("single_aok", 64'(m_addr_ok_o[0]), 64'(3'b001));
        chk("single_addr", 64'(s_addr_o[0]), 64'(32'h1C00_0000));
        tick();
        idle(); cyc();
        s_data_ok = 1; s_rdata = 32'h1234_5678;
        step();
        chk("single_dok", 64'(m_data_ok_o[0]), 64'(3'b001));
        chk("single_rdata", 64'(m_rdata_o[0][31:0]), 64'(32'h1234_5678));
        tick();

        // Round-robin vs fixed priority with ch0 and ch1 requesting continuously
        do_reset();
        m_req = 3'b011; s_addr_ok = 1; s_data_ok = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_grant", 64'(m_addr_ok_o[0]), 64'((i % 2 == 0) ? 3'b001 : 3'b010));
            chk("fp_grant", 64'(m_addr_ok_o[1]), 64'(3'b001));
            tick();
        end

        // Full: four accepted, fifth stalls; a pop at edge t grants in t+1
        do_reset();
        m_req = 3'b001; s_addr_ok = 1;
        for (int i = 0; i < 4; i++) cyc();
        s_data_ok = 1;
        step();
        chk("full_sreq", 64'(s_req_o[0]), 64'(0));
        tick();
        s_data_ok = 0;
        step();
        chk("after_pop_aok", 64'(m_addr_ok_o[0]), 64'(3'b001));
        tick();

        // Cancel: queue ch1,ch0,ch1; cancel ch1; only the middle response survives
        do_reset();
        s_addr_ok = 1;
        m_req = 3'b010; cyc();
        m_req = 3'b001; cyc();
        m_req = 3'b010; cyc();
        idle(); m_cancel = 3'b010; cyc();
        m_cancel = '0; s_data_ok = 1;
        for (int i = 0; i < 3; i++) begin
            s_rdata = 32'hA000_0000 + 32'(i);
            step();
            chk("cancel_dok", 64'(m_data_ok_o[0]), 64'((i == 1) ? 3'b001 : 3'b000));
            tick();
        end

        // Lock: ch1 stalled three cycles, ch0 arrives meanwhile
        do_reset();
        m_req = 3'b010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lock_addr", 64'(s_addr_o[1]), 64'(32'h2000_0000));
            tick();
            m_req = 3'b011;
        end
        s_addr_ok = 1;
        step();
        chk("lock_release", 64'(m_addr_ok_o[1]), 64'(3'b010));
        tick();
        m_req = 3'b001;
        step();
        chk("lock_next", 64'(m_addr_ok_o[1]), 64'(3'b001));
        tick();

        // Reset mid-operation drops outstanding entries
        do_reset();
        s_addr_ok = 1;
        m_req = 3'b001; cyc();
        m_req = 3'b010; cyc();
        do_reset();
        idle(); s_data_ok = 1;
        step();
        chk("post_reset_dok", 64'(m_data_ok_o[0]), 64'(0));
        tick();
        idle(); m_req = 3'b011; s_addr_ok = 1;
        step();
        chk("post_reset_grant", 64'(m_addr_ok_o[0]), 64'(3'b001));
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            resetn    = ($urandom_range(0, 199) != 0);
            m_req     = NC'($urandom);
            m_wr      = NC'($urandom);
            m_size    = (2*NC)'($urandom);
            m_wstrb   = (NC*4)'($urandom);
            m_addr    = {$urandom, $urandom, $urandom};
            m_wdata   = {$urandom, $urandom, $urandom};
            m_cancel  = '0;
            for (int c = 0; c < NC; c++)
                if ($urandom_range(0, 9) == 0) m_cancel = m_cancel | (NC'(1) << c);
            s_addr_ok = ($urandom_range(0, 9) < 6);
            s_data_ok = ($urandom_range(0, 1) == 1);
            s_rdata   = $urandom;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
